// File: rtl/travel_plan_seq.sv
// Travel-plan sequencer: latches a 16-bit plan of 2-bit maneuvers and issues one
// maneuver request per qualified line gap, pausing with the buzzer on while a bumper is pressed.
module travel_plan_seq #(
    parameter int GAP_CLKS    = 4096,
    parameter int RESUME_CLKS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        line_present,
    input  logic        BMPL_n,
    input  logic        BMPR_n,
    output logic        go,
    output logic        veer_rt,
    output logic        veer_lft,
    output logic        turn_around,
    output logic        buzz_en,
    output logic        plan_done
);

    localparam int GW = $clog2(GAP_CLKS) + 1;
    localparam int RW = $clog2(RESUME_CLKS) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
    localparam logic [GW-1:0] GAP_MAX  = {GW{1'b1}};
    localparam logic [RW-1:0] RSM_LAST = RW'(RESUME_CLKS - 1);
    localparam logic [RW-1:0] RSM_MAX  = {RW{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        GAP   = 3'd3,
        OBSTR = 3'd4
    } state_t;

    state_t        state_q;
    logic [15:0]   plan_q;
    logic [3:0]    idx_q;
    logic [GW-1:0] gap_cnt_q;
    logic [GW-1:0] gap_cnt_d;
    logic [RW-1:0] rsm_cnt_q;
    logic [RW-1:0] rsm_cnt_d;
    logic          clr_q;
    logic          go_q;
    logic          vr_q;
    logic          vl_q;
    logic          ta_q;
    logic          buzz_q;
    logic          done_q;

    logic          bump_s;
    logic          gap_hit_s;
    logic          rsm_hit_s;
    logic          stop_s;
    logic [1:0]    field_s;

    assign bump_s    = ~BMPL_n | ~BMPR_n;
    assign field_s   = plan_q[1:0];
    assign gap_hit_s = ~line_present & (gap_cnt_q == GAP_LAST);
    assign rsm_hit_s = ~bump_s & (rsm_cnt_q == RSM_LAST);
    // An exhausted plan behaves exactly like an explicit stop field.
    assign stop_s    = (field_s == 2'b00) | (idx_q == 4'd8);

    // Saturating next values for the gap and resume counters.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        rsm_cnt_d = rsm_cnt_q;
        if (line_present) begin
            gap_cnt_d = {GW{1'b0}};
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + {{(GW-1){1'b0}}, 1'b1};
        end else begin
            gap_cnt_d = gap_cnt_q;
        end
        if (bump_s) begin
            rsm_cnt_d = {RW{1'b0}};
        end else if (rsm_cnt_q != RSM_MAX) begin
            rsm_cnt_d = rsm_cnt_q + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            rsm_cnt_d = rsm_cnt_q;
        end
    end

    // Sequencer state machine with registered request, ack and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            plan_q    <= 16'h0000;
            idx_q     <= 4'd0;
            gap_cnt_q <= {GW{1'b0}};
            rsm_cnt_q <= {RW{1'b0}};
            clr_q     <= 1'b0;
            go_q      <= 1'b0;
            vr_q      <= 1'b0;
            vl_q      <= 1'b0;
            ta_q      <= 1'b0;
            buzz_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            vr_q  <= 1'b0;
            vl_q  <= 1'b0;
            ta_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_rdy) begin
                        plan_q  <= cmd;
                        clr_q   <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    go_q      <= 1'b1;
                    idx_q     <= 4'd0;
                    done_q    <= 1'b0;
                    gap_cnt_q <= {GW{1'b0}};
                    state_q   <= RUN;
                end
                RUN: begin
                    if (bump_s) begin
                        go_q      <= 1'b0;
                        buzz_q    <= 1'b1;
                        gap_cnt_q <= {GW{1'b0}};
                        rsm_cnt_q <= {RW{1'b0}};
                        state_q   <= OBSTR;
                    end else if (gap_hit_s) begin
                        gap_cnt_q <= {GW{1'b0}};
                        if (stop_s) begin
                            go_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            vr_q    <= (field_s == 2'b01);
                            vl_q    <= (field_s == 2'b10);
                            ta_q    <= (field_s == 2'b11);
                            plan_q  <= {2'b00, plan_q[15:2]};
                            idx_q   <= idx_q + 4'd1;
                            state_q <= GAP;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end
                GAP: begin
                    // Wait for the line to return so one long gap consumes one field.
                    if (bump_s) begin
                        go_q      <= 1'b0;
                        buzz_q    <= 1'b1;
                        gap_cnt_q <= {GW{1'b0}};
                        rsm_cnt_q <= {RW{1'b0}};
                        state_q   <= OBSTR;
                    end else if (line_present) begin
                        gap_cnt_q <= {GW{1'b0}};
                        state_q   <= RUN;
                    end else begin
                        gap_cnt_q <= {GW{1'b0}};
                    end
                end
                OBSTR: begin
                    if (rsm_hit_s) begin
                        buzz_q    <= 1'b0;
                        go_q      <= 1'b1;
                        rsm_cnt_q <= {RW{1'b0}};
                        gap_cnt_q <= {GW{1'b0}};
                        state_q   <= RUN;
                    end else begin
                        rsm_cnt_q <= rsm_cnt_d;
                    end
                end
                default: begin
                    go_q      <= 1'b0;
                    buzz_q    <= 1'b0;
                    gap_cnt_q <= {GW{1'b0}};
                    rsm_cnt_q <= {RW{1'b0}};
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign clr_cmd_rdy = clr_q;
    assign go          = go_q;
    assign veer_rt     = vr_q;
    assign veer_lft    = vl_q;
    assign turn_around = ta_q;
    assign buzz_en     = buzz_q;
    assign plan_done   = done_q;

endmodule

// File: doc/travel_plan_seq.md
Name: travel_plan_seq

Overview:
- Command sequencer between the UART command receiver and the line-following motion control in MazeRunner.
- Latches a 16-bit travel plan of eight 2-bit maneuver fields, consumed LSB-first, one field per qualified line gap.
- Issues go, veer-right, veer-left and turn-around requests to the heading/motor logic.
- Halts and sounds the buzzer while a bump switch is pressed, then resumes the plan.

Parameters:
GAP_CLKS, 4096, consecutive cycles with line_present=0 required to qualify a gap
RESUME_CLKS, 1024, cycles both bump inputs must stay released before motion resumes

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cmd  input  16  travel plan word from UART receiver
cmd_rdy  input  1  cmd holds a new, unconsumed plan
clr_cmd_rdy  output  1  one-cycle pulse acknowledging cmd capture
line_present  input  1  IR line-detect flag from sensor stage
BMPL_n  input  1  left bump switch, active low, already synchronized
BMPR_n  input  1  right bump switch, active low, already synchronized
go  output  1  motion enable to motor control
veer_rt  output  1  one-cycle request: veer right
veer_lft  output  1  one-cycle request: veer left
turn_around  output  1  one-cycle request: 180-degree turn
buzz_en  output  1  piezo driver enable
plan_done  output  1  level, high after a stop field or plan exhaustion until next capture

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - outputs: go, veer_rt, veer_lft, turn_around, buzz_en, clr_cmd_rdy and plan_done all 0.
  - internal: state=IDLE, plan register=0, field index=0, gap and resume counters=0.
  - Reset mid-maneuver or mid-obstruction aborts immediately; no pulse is emitted on the reset cycle.
- Field encoding, plan[1:0] first: 00 stop, 01 veer right, 10 veer left, 11 turn around.
- IDLE:
  - on cmd_rdy=1, capture cmd into plan and pulse clr_cmd_rdy the same cycle.
  - next cycle: go=1, index=0, plan_done=0, state→RUN.
  - cmd_rdy in any other state is left pending (no clr_cmd_rdy) until IDLE is re-entered.
- RUN:
  - gap counter increments each cycle line_present=0 and clears on any line_present=1.
  - when the counter reaches GAP_CLKS-1 with line still absent, decode plan[1:0] on the next edge:
    - 01/10/11: pulse veer_rt/veer_lft/turn_around for exactly one cycle, shift plan right by 2, index+1, state→GAP.
    - 00: go=0, plan_done=1, state→IDLE, no request pulse.
  - Latency: the pulse is asserted GAP_CLKS cycles after the first absent sample.
- GAP:
  - holds until line_present=1, then clears the gap counter and returns to RUN.
  - prevents a single long gap (e.g. a turn-around of 1.75M cycles) from consuming more than one field.
- Exhaustion: a qualified gap in RUN with index=8 is treated as a stop field.
- OBSTR:
  - entered from RUN or GAP on any cycle where BMPL_n=0 or BMPR_n=0.
  - the next cycle: go=0, buzz_en=1; gap counter cleared; return state recorded as RUN.
  - Bump has priority over gap qualification on the same cycle: no field consumed, no pulse.
  - buzz_en stays 1 while either bump is low.
  - once both are high, the resume counter runs; any re-press clears it.
  - at RESUME_CLKS-1: buzz_en=0, go=1, state→RUN.
  - A bump in IDLE is ignored: go stays 0, buzz_en stays 0.
- Request pulses are mutually exclusive and never coincide with clr_cmd_rdy.
- Counter widths: gap counter $clog2(GAP_CLKS)+1 bits, resume counter $clog2(RESUME_CLKS)+1 bits; both saturate and never wrap.

Test Plan:
- Capture and acknowledge: cmd=16'h5555, pulse cmd_rdy → clr_cmd_rdy 1 cycle, go=1 next cycle, plan_done=0.
- Gap qualification: line_present=0 for GAP_CLKS-1 cycles then restored → no pulse, go stays 1. Repeat with a 300000-cycle gap → exactly one veer_rt pulse at GAP_CLKS latency.
- Full plan, cmd=16'h002D: four gaps (300000, 1750000, 300000, 100000 cycles) → veer_rt, turn_around, veer_lft, then go=0 with plan_done=1, no fourth pulse.
- Exhaustion, cmd=16'hFFFF: nine qualified gaps → eight turn_around pulses; ninth gap gives go=0, plan_done=1.
- Obstruction, plan 16'h002D after the first maneuver:
  - BMPR_n=0 for 5000 cycles → go=0 and buzz_en=1 from the next cycle.
  - release → go=1, buzz_en=0 exactly RESUME_CLKS cycles later; remaining fields proceed unchanged.
  - repeat with BMPL_n; a bump asserted on the gap-qualifying cycle consumes no field.
- Reset mid-GAP with cmd_rdy held high: all outputs 0. After release, cmd is recaptured with clr_cmd_rdy pulsed once.
